// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - SPI slave endpoint: oversampled pins, all CPOL/CPHA modes, one-entry TX buffer.
// Optional SPI_SLAVE_RX_HOLD_EN: rx_valid held until rx_ready, rx_overrun flags dropped words.
module spi_slave_core #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  cs,
   input  logic                  sck,
   input  logic                  mosi,
   output logic                  miso,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  tx_underrun,
`ifdef SPI_SLAVE_RX_HOLD_EN
   input  logic                  rx_ready,
   output logic                  rx_overrun,
`endif
   output logic                  rx_abort
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   localparam int            CW       = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   cs_hist_q, cs_hist_d;
   logic                   sck_hist_q, sck_hist_d;
   state_t                 state_q, state_d;
   logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-2:0]  rx_sh_q, rx_sh_d;
   logic [DATA_WIDTH-1:0]  tx_sh_q, tx_sh_d;
   logic [DATA_WIDTH-1:0]  tx_buf_q, tx_buf_d;
   logic                   tx_full_q, tx_full_d;
   logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   tx_underrun_q, tx_underrun_d;
   logic                   rx_abort_q, rx_abort_d;
   logic                   first_launch_q, first_launch_d;
   logic                   load_pend_q, load_pend_d;
`ifdef SPI_SLAVE_RX_HOLD_EN
   logic                   rx_overrun_q, rx_overrun_d;
`endif

   logic cs_s, sck_s, mosi_s;
   logic cs_fall, cs_rise, sck_rise, sck_fall, sample_edge, launch_edge;
   logic load, word_done;

   assign cs_s        = cs_sync_q[SYNC_STAGES-1];
   assign sck_s       = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   assign cs_fall     = cs_hist_q & ~cs_s;
   assign cs_rise     = ~cs_hist_q & cs_s;
   assign sck_rise    = ~sck_hist_q & sck_s;
   assign sck_fall    = sck_hist_q & ~sck_s;
   assign sample_edge = (cpol == cpha) ? sck_rise : sck_fall;
   assign launch_edge = (cpol == cpha) ? sck_fall : sck_rise;

   always_comb begin
      cs_sync_d      = {cs_sync_q[SYNC_STAGES-2:0], cs};
      sck_sync_d     = {sck_sync_q[SYNC_STAGES-2:0], sck};
      mosi_sync_d    = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_hist_d      = cs_s;
      sck_hist_d     = sck_s;
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      rx_sh_d        = rx_sh_q;
      tx_sh_d        = tx_sh_q;
      tx_buf_d       = tx_buf_q;
      tx_full_d      = tx_full_q;
      rx_data_d      = rx_data_q;
      tx_underrun_d  = 1'b0;
      rx_abort_d     = 1'b0;
      first_launch_d = first_launch_q;
      load_pend_d    = load_pend_q;
      load           = 1'b0;
      word_done      = 1'b0;
`ifdef SPI_SLAVE_RX_HOLD_EN
      rx_valid_d     = rx_valid_q & ~rx_ready;
      rx_overrun_d   = 1'b0;
`else
      rx_valid_d     = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (cs_fall) state_d = LOAD;
         end
         LOAD: begin
            load           = 1'b1;
            bit_cnt_d      = '0;
            first_launch_d = cpha;
            load_pend_d    = 1'b0;
            state_d        = cs_rise ? IDLE : SHIFT;
         end
         SHIFT: begin
            // The sample is processed before cs rise so a coincident final edge still completes the word.
            if (sample_edge) begin
               rx_sh_d = {rx_sh_q[DATA_WIDTH-3:0], mosi_s};
               if (bit_cnt_q == LAST_BIT) begin
                  word_done   = 1'b1;
                  bit_cnt_d   = '0;
                  load_pend_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end
            end
            if (cs_rise) begin
               if (bit_cnt_d != '0) rx_abort_d = 1'b1;
               bit_cnt_d   = '0;
               load_pend_d = 1'b0;
               state_d     = IDLE;
            end else if (launch_edge) begin
               if (load_pend_q) begin
                  load        = 1'b1;
                  load_pend_d = 1'b0;
               end else if (first_launch_q) begin
                  first_launch_d = 1'b0;
               end else begin
                  tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         tx_sh_d       = tx_full_q ? tx_buf_q : '0;
         tx_underrun_d = ~tx_full_q;
         tx_full_d     = 1'b0;
      end
      // Acceptance looks at the pre-load occupancy, so a coincident push lands one cycle later.
      if (tx_valid && !tx_full_q) begin
         tx_buf_d  = tx_data;
         tx_full_d = 1'b1;
      end

      if (word_done) begin
`ifdef SPI_SLAVE_RX_HOLD_EN
         if (rx_valid_q && !rx_ready) begin
            rx_overrun_d = 1'b1;
         end else begin
            rx_data_d  = {rx_sh_q, mosi_s};
            rx_valid_d = 1'b1;
         end
`else
         rx_data_d  = {rx_sh_q, mosi_s};
         rx_valid_d = 1'b1;
`endif
      end
   end

   // Synchronisers reset low so a cs already held low at release is not mistaken for a fresh fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_sync_q      <= '0;
         sck_sync_q     <= '0;
         mosi_sync_q    <= '0;
         cs_hist_q      <= 1'b0;
         sck_hist_q     <= 1'b0;
         state_q        <= IDLE;
         bit_cnt_q      <= '0;
         rx_sh_q        <= '0;
         tx_sh_q        <= '0;
         tx_buf_q       <= '0;
         tx_full_q      <= 1'b0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         tx_underrun_q  <= 1'b0;
         rx_abort_q     <= 1'b0;
         first_launch_q <= 1'b0;
         load_pend_q    <= 1'b0;
`ifdef SPI_SLAVE_RX_HOLD_EN
         rx_overrun_q   <= 1'b0;
`endif
      end else begin
         cs_sync_q      <= cs_sync_d;
         sck_sync_q     <= sck_sync_d;
         mosi_sync_q    <= mosi_sync_d;
         cs_hist_q      <= cs_hist_d;
         sck_hist_q     <= sck_hist_d;
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         rx_sh_q        <= rx_sh_d;
         tx_sh_q        <= tx_sh_d;
         tx_buf_q       <= tx_buf_d;
         tx_full_q      <= tx_full_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         tx_underrun_q  <= tx_underrun_d;
         rx_abort_q     <= rx_abort_d;
         first_launch_q <= first_launch_d;
         load_pend_q    <= load_pend_d;
`ifdef SPI_SLAVE_RX_HOLD_EN
         rx_overrun_q   <= rx_overrun_d;
`endif
      end
   end

   assign miso        = tx_sh_q[DATA_WIDTH-1];
   assign tx_ready    = ~tx_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_underrun = tx_underrun_q;
   assign rx_abort    = rx_abort_q;
`ifdef SPI_SLAVE_RX_HOLD_EN
   assign rx_overrun  = rx_overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// tb/tb_spi_slave_core.sv - self-checking bench for spi_slave_core (SPI master model, table + random frames).
module tb_spi_slave_core;

   localparam int HALF = 8;

   typedef struct packed {
      logic [1:0]      mode;          // {cpol, cpha}
      logic [1:0]      nwords;
      logic [3:0]      nbits_last;
      logic [2:0][7:0] mosi_w;
      logic [2:0]      ntx;
      logic [3:0][7:0] tx_w;
      logic [1:0]      exp_nrx;
      logic [2:0][7:0] exp_rx;
      logic [2:0][7:0] exp_miso;
      logic [2:0]      exp_underrun;
      logic            exp_abort;
   } vec_t;

   logic       clk, rst, cpol, cpha, cs, sck, mosi, miso;
   logic [7:0] tx_data, rx_data;
   logic       tx_valid, tx_ready, rx_valid, tx_underrun, rx_abort;
`ifdef SPI_SLAVE_RX_HOLD_EN
   logic       rx_ready, rx_overrun;
   int         ovr_total = 0;
`endif

   int         checks = 0, failures = 0;
   int         und_total = 0, abort_total = 0;
   logic [7:0] rx_log[$];
   logic       tx_done;
   vec_t       vecs[8];

   spi_slave_core #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .cs(cs), .sck(sck), .mosi(mosi),
      .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
`ifdef SPI_SLAVE_RX_HOLD_EN
      .rx_ready(rx_ready), .rx_overrun(rx_overrun),
`endif
      .rx_abort(rx_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) rx_log.push_back(rx_data);
         if (tx_underrun) und_total++;
         if (rx_abort) abort_total++;
`ifdef SPI_SLAVE_RX_HOLD_EN
         if (rx_overrun) ovr_total++;
`endif
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Word starts: cpha=0 reloads on the launch edge after every completed word, cpha=1 only when a word begins.
   function automatic int loads_of(input vec_t v);
      int full;
      full = (v.nbits_last == 4'd8) ? int'(v.nwords) : int'(v.nwords) - 1;
      return v.mode[0] ? int'(v.nwords) : full + 1;
   endfunction

   function automatic vec_t model(input vec_t v);
      vec_t r;
      int   full;
      r = v;
      full = (v.nbits_last == 4'd8) ? int'(v.nwords) : int'(v.nwords) - 1;
      r.exp_nrx = 2'(full);
      r.exp_rx = '0;
      r.exp_miso = '0;
      for (int k = 0; k < full; k++) begin
         r.exp_rx[k] = v.mosi_w[k];
         r.exp_miso[k] = (k < int'(v.ntx)) ? v.tx_w[k] : 8'h00;
      end
      r.exp_underrun = 3'(loads_of(v) - int'(v.ntx));
      r.exp_abort = (v.nbits_last != 4'd8);
      return r;
   endfunction

   function automatic vec_t mkv(input logic [1:0] mode, input int nw, input int nb, input logic [23:0] mw,
                                input int ntx, input logic [31:0] tw, input int enrx, input logic [23:0] erx,
                                input logic [23:0] emiso, input int eund, input int eab);
      vec_t v;
      v.mode = mode;  v.nwords = 2'(nw);  v.nbits_last = 4'(nb);  v.mosi_w = mw;
      v.ntx = 3'(ntx);  v.tx_w = tw;  v.exp_nrx = 2'(enrx);  v.exp_rx = erx;
      v.exp_miso = emiso;  v.exp_underrun = 3'(eund);  v.exp_abort = (eab != 0);
      return v;
   endfunction

   task automatic half_wait();
      repeat (HALF) @(negedge clk);
   endtask

   task automatic refill(input vec_t v);
      int t;
      for (int i = 0; i < int'(v.ntx); i++) begin
         t = 0;
         while (!tx_ready && t < 2000) begin
            @(negedge clk);
            t++;
         end
         tx_data = v.tx_w[i];
         tx_valid = 1'b1;
         @(negedge clk);
         tx_valid = 1'b0;
         @(negedge clk);
      end
      tx_done = 1'b1;
   endtask

   task automatic run_frame(input vec_t v, output logic [2:0][7:0] got);
      logic cp, ch, b_o;
      int   nb;
      cp = v.mode[1];
      ch = v.mode[0];
      cs = 1'b1;  sck = cp;  cpol = cp;  cpha = ch;
      half_wait();
      cs = 1'b0;
      got = '0;
      for (int w = 0; w < int'(v.nwords); w++) begin
         nb = (w == int'(v.nwords) - 1) ? int'(v.nbits_last) : 8;
         for (int b = 0; b < nb; b++) begin
            b_o = v.mosi_w[w][7-b];
            if (!ch) begin
               mosi = b_o;
               half_wait();
               sck = ~cp;
               got[w] = {got[w][6:0], miso};
               half_wait();
               sck = cp;
            end else begin
               half_wait();
               sck = ~cp;
               mosi = b_o;
               half_wait();
               sck = cp;
               got[w] = {got[w][6:0], miso};
            end
         end
      end
      half_wait();
      cs = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic apply(input vec_t v, input string name);
      int               rx0, und0, ab0, nrx;
      logic [2:0][7:0]  got;
      rx0 = rx_log.size();  und0 = und_total;  ab0 = abort_total;
      tx_done = 1'b0;
      fork
         refill(v);
      join_none
      repeat (4) @(negedge clk);
      run_frame(v, got);
      for (int i = 0; i < 4000 && !tx_done; i++) @(negedge clk);
      check({name, "_refill_done"}, 32'(tx_done), 32'd1);
      nrx = rx_log.size() - rx0;
      check({name, "_rx_count"}, 32'(nrx), 32'(v.exp_nrx));
      for (int k = 0; k < int'(v.exp_nrx); k++) begin
         if (rx0 + k < rx_log.size())
            check($sformatf("%s_rx%0d", name, k), 32'(rx_log[rx0+k]), 32'(v.exp_rx[k]));
         check($sformatf("%s_miso%0d", name, k), 32'(got[k]), 32'(v.exp_miso[k]));
      end
      check({name, "_underrun"}, 32'(und_total - und0), 32'(v.exp_underrun));
      check({name, "_abort"}, 32'(abort_total - ab0), 32'(v.exp_abort));
      check({name, "_tx_ready_end"}, 32'(tx_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_miso"}, 32'(miso), 32'd0);
      check({name, "_tx_ready"}, 32'(tx_ready), 32'd1);
      check({name, "_rx_data"}, 32'(rx_data), 32'd0);
      check({name, "_rx_valid"}, 32'(rx_valid), 32'd0);
      check({name, "_tx_underrun"}, 32'(tx_underrun), 32'd0);
      check({name, "_rx_abort"}, 32'(rx_abort), 32'd0);
   endtask

   initial begin
      vec_t v;
      int   ld;
      rst = 1'b1;  cpol = 1'b0;  cpha = 1'b0;  cs = 1'b1;  sck = 1'b0;  mosi = 1'b0;
      tx_data = 8'h00;  tx_valid = 1'b0;  tx_done = 1'b0;
`ifdef SPI_SLAVE_RX_HOLD_EN
      rx_ready = 1'b1;
`endif
      //           mode   nw nb mosi        ntx tx             nrx rx          miso        und ab
      vecs[0] = mkv(2'b00, 1, 8, 24'h00003C, 2, 32'h000000A5, 1, 24'h00003C, 24'h0000A5, 0, 0);
      vecs[1] = mkv(2'b01, 1, 8, 24'h000081, 1, 32'h0000007E, 1, 24'h000081, 24'h00007E, 0, 0);
      vecs[2] = mkv(2'b10, 1, 8, 24'h000081, 2, 32'h0000007E, 1, 24'h000081, 24'h00007E, 0, 0);
      vecs[3] = mkv(2'b11, 1, 8, 24'h000081, 1, 32'h0000007E, 1, 24'h000081, 24'h00007E, 0, 0);
      vecs[4] = mkv(2'b00, 3, 8, 24'h332211, 4, 32'hC4C3C2C1, 3, 24'h332211, 24'hC3C2C1, 0, 0);
      vecs[5] = mkv(2'b01, 1, 8, 24'h000096, 0, 32'h00000000, 1, 24'h000096, 24'h000000, 1, 0);
      vecs[6] = mkv(2'b00, 1, 5, 24'h0000AB, 1, 32'h00000055, 0, 24'h000000, 24'h000000, 0, 1);
      vecs[7] = mkv(2'b00, 1, 8, 24'h0000F0, 2, 32'h0000000F, 1, 24'h0000F0, 24'h00000F, 0, 0);

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 8; i++) apply(vecs[i], $sformatf("dir%0d", i));

      // Reset in the middle of a word, then a clean transfer.
      cpol = 1'b0;  cpha = 1'b0;  sck = 1'b0;  cs = 1'b1;
      repeat (8) @(negedge clk);
      tx_data = 8'h99;  tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      @(negedge clk);
      check("rst_seq_tx_ready_full", 32'(tx_ready), 32'd0);
      cs = 1'b0;  mosi = 1'b1;
      half_wait();
      check("rst_seq_tx_ready_after_load", 32'(tx_ready), 32'd1);
      for (int b = 0; b < 4; b++) begin
         sck = 1'b1;
         half_wait();
         sck = 1'b0;
         half_wait();
      end
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst_mid");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cs = 1'b1;
      repeat (8) @(negedge clk);
      apply(mkv(2'b00, 1, 8, 24'h00005A, 2, 32'h000000C3, 1, 24'h00005A, 24'h0000C3, 0, 0), "after_rst");
      check("after_rst_rx_data", 32'(rx_data), 32'h5A);

      for (int n = 0; n < 20; n++) begin
         v = '0;
         v.mode = 2'($urandom_range(0, 3));
         v.nwords = 2'($urandom_range(1, 3));
         v.nbits_last = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 7)) : 4'd8;
         v.mosi_w = 24'($urandom);
         v.tx_w = 32'($urandom);
         ld = loads_of(v);
         v.ntx = 3'($urandom_range(0, ld));
         v = model(v);
         apply(v, $sformatf("rnd%0d", n));
      end

`ifdef SPI_SLAVE_RX_HOLD_EN
      begin
         int              ov0;
         logic [2:0][7:0] got;
         ov0 = ovr_total;
         rx_ready = 1'b0;
         @(negedge clk);
         run_frame(mkv(2'b01, 2, 8, 24'h00B2A1, 0, 32'h0, 2, 24'h00B2A1, 24'h0, 2, 0), got);
         check("hold_rx_data", 32'(rx_data), 32'hA1);
         check("hold_rx_valid", 32'(rx_valid), 32'd1);
         check("hold_overrun", 32'(ovr_total - ov0), 32'd1);
         rx_ready = 1'b1;
         @(negedge clk);
         check("hold_release", 32'(rx_valid), 32'd0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
